// File: rtl/linear_bias_grad_batched_pkg.sv
// linear_bias_grad_batched_pkg: shared fpu definitions (fp32 type, constants, reducer state enum)
package linear_bias_grad_batched_pkg;
  localparam int ADDR_W = 32;
  typedef logic [31:0] fp32_t;
  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_QNAN = 32'h7FC0_0000;
  typedef enum logic [2:0] {IDLE, SETUP, RD_PRIOR, RD_GRAD, ADD, WRITE, DONE} state_t;
endpackage

// File: rtl/linear_bias_grad_batched_if.sv
// linear_bias_grad_batched_if: memory handle, a word-addressed region with an avail/done access handshake
interface linear_bias_grad_batched_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] region_begin, region_end, ptr;
  logic              r_en, w_en, avail, done, write_through;
  logic [31:0]       data_load, data_store;
  modport master(input region_begin, region_end, done, data_load,
                 output ptr, r_en, w_en, avail, data_store, write_through);
  modport slave(output region_begin, region_end, done, data_load,
                input ptr, r_en, w_en, avail, data_store, write_through);
endinterface

// File: rtl/linear_bias_grad_batched_fp32_add.sv
// linear_bias_grad_batched_fp32_add: combinational IEEE-754 fp32 adder, round-to-nearest-even
module linear_bias_grad_batched_fp32_add
  import linear_bias_grad_batched_pkg::*;
(
  input  fp32_t x_i,
  input  fp32_t y_i,
  output fp32_t sum_o
);
  fp32_t       big, sml;
  logic [7:0]  eb, es, dd;
  logic [26:0] mb, ms, msh;
  logic [27:0] sum;
  logic [26:0] n;
  logic [4:0]  lz, sh;
  logic [9:0]  e, ef;
  logic [24:0] mr;
  logic [23:0] mf;
  logic        sub, stk, rnd, x_inf, y_inf, nan;
  always_comb begin
    big = (y_i[30:0] > x_i[30:0]) ? y_i : x_i;
    sml = (y_i[30:0] > x_i[30:0]) ? x_i : y_i;
    eb  = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es  = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb  = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms  = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    dd  = eb - es;
    sub = big[31] ^ sml[31];
    stk = (dd > 8'd26) ? (ms != 27'd0) : ((ms & ((27'd1 << dd) - 27'd1)) != 27'd0);
    msh = ((dd > 8'd26) ? 27'd0 : (ms >> dd)) | 27'(stk);
    sum = sub ? ({1'b0, mb} - {1'b0, msh}) : ({1'b0, mb} + {1'b0, msh});
    lz  = 5'd27;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    // Left normalisation stops at the minimum exponent so tiny results come out subnormal
    sh  = ({3'b000, lz} < eb) ? lz : 5'(eb - 8'd1);
    n   = sum[27] ? {sum[27:2], sum[1] | sum[0]} : (sum[26:0] << sh);
    e   = sum[27] ? ({2'b00, eb} + 10'd1) : ({2'b00, eb} - {5'b00000, sh});
    rnd = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[26:3]} + 25'(rnd);
    ef  = mr[24] ? e + 10'd1 : e;
    mf  = mr[24] ? mr[24:1] : mr[23:0];
    x_inf = (x_i[30:23] == 8'hFF) && (x_i[22:0] == 23'd0);
    y_inf = (y_i[30:23] == 8'hFF) && (y_i[22:0] == 23'd0);
    nan   = ((x_i[30:23] == 8'hFF) && !x_inf) || ((y_i[30:23] == 8'hFF) && !y_inf) ||
            (x_inf && y_inf && (x_i[31] ^ y_i[31]));
    sum_o = nan            ? FP32_QNAN :
            x_inf          ? x_i :
            y_inf          ? y_i :
            (sum == 28'd0) ? {big[31] & sml[31], 31'd0} :
            (ef >= 10'd255) ? {big[31], 8'hFF, 23'd0} :
            {big[31], mf[23] ? ef[7:0] : 8'd0, mf[22:0]};
  end
endmodule

// File: rtl/linear_bias_grad_batched.sv
// linear_bias_grad_batched: column-sum of an fp32 gradient matrix into a bias-gradient vector
module linear_bias_grad_batched
  import linear_bias_grad_batched_pkg::*;
#(
  parameter int ROW_W = 16,
  parameter int COL_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_l,
  linear_bias_grad_batched_if.master  a,
  linear_bias_grad_batched_if.master  d,
  input  logic                        go,
  input  logic                        accumulate,
  input  logic [ROW_W-1:0]            n_rows,
  input  logic [COL_W-1:0]            n_cols,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  state_t              state_q, state_d;
  logic [ROW_W-1:0]    rows_q, rows_d, row_q, row_d;
  logic [COL_W-1:0]    cols_q, cols_d, col_q, col_d;
  logic                mode_q, mode_d, err_q, err_d;
  fp32_t               acc_q, acc_d, op_q, op_d, sum;
  logic [ADDR_W-1:0]   aptr_q, aptr_d, dptr_q, dptr_d, a_span, d_span;
  logic [ROW_W+COL_W-1:0] cells;
  logic                bad, last_row, last_col;
  linear_bias_grad_batched_fp32_add u_add (.x_i(acc_q), .y_i(op_q), .sum_o(sum));
  assign cells    = (ROW_W+COL_W)'(rows_q) * (ROW_W+COL_W)'(cols_q);
  assign a_span   = a.region_end - a.region_begin;
  assign d_span   = d.region_end - d.region_begin;
  assign bad      = (64'(cells) > 64'(a_span)) || (64'(cols_q) > 64'(d_span));
  assign last_row = row_q == rows_q - ROW_W'(1);
  assign last_col = col_q == cols_q - COL_W'(1);
  assign busy            = (state_q != IDLE) && (state_q != DONE);
  assign done            = state_q == DONE;
  assign err             = err_q;
  assign a.ptr           = aptr_q;
  assign a.r_en          = state_q == RD_GRAD;
  assign a.avail         = state_q == RD_GRAD;
  assign a.w_en          = 1'b0;
  assign a.data_store    = FP32_ZERO;
  assign a.write_through = 1'b0;
  assign d.ptr           = dptr_q;
  assign d.r_en          = state_q == RD_PRIOR;
  assign d.w_en          = state_q == WRITE;
  assign d.avail         = (state_q == RD_PRIOR) || (state_q == WRITE);
  assign d.data_store    = (state_q == WRITE) ? acc_q : FP32_ZERO;
  assign d.write_through = (state_q == WRITE) && last_col;
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    op_d    = op_q;
    err_d   = err_q;
    aptr_d  = aptr_q;
    dptr_d  = dptr_q;
    case (state_q)
      IDLE: if (go) begin
        rows_d  = n_rows;
        cols_d  = n_cols;
        mode_d  = accumulate;
        state_d = SETUP;
      end
      SETUP: begin
        err_d   = bad;
        row_d   = '0;
        col_d   = '0;
        aptr_d  = a.region_begin;
        dptr_d  = d.region_begin;
        acc_d   = FP32_ZERO;
        state_d = (bad || rows_q == '0 || cols_q == '0) ? DONE : (mode_q ? RD_PRIOR : RD_GRAD);
      end
      RD_PRIOR: if (d.done) begin
        acc_d   = d.data_load;
        state_d = RD_GRAD;
      end
      RD_GRAD: if (a.done) begin
        op_d    = a.data_load;
        aptr_d  = aptr_q + ADDR_W'(cols_q);
        state_d = ADD;
      end
      ADD: begin
        acc_d   = sum;
        row_d   = last_row ? row_q : row_q + ROW_W'(1);
        state_d = last_row ? WRITE : RD_GRAD;
      end
      WRITE: if (d.done) begin
        dptr_d = dptr_q + ADDR_W'(1);
        if (last_col) state_d = DONE;
        else begin
          col_d   = col_q + COL_W'(1);
          row_d   = '0;
          aptr_d  = a.region_begin + ADDR_W'(col_q) + ADDR_W'(1);
          acc_d   = FP32_ZERO;
          state_d = mode_q ? RD_PRIOR : RD_GRAD;
        end
      end
      DONE: if (!go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      mode_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= FP32_ZERO;
      op_q    <= FP32_ZERO;
      err_q   <= 1'b0;
      aptr_q  <= '0;
      dptr_q  <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      err_q   <= err_d;
      aptr_q  <= aptr_d;
      dptr_q  <= dptr_d;
    end
  end
endmodule

// File: tb/tb_linear_bias_grad_batched.sv
// tb_linear_bias_grad_batched: directed scoreboard bench with stalling memory models for a and d
module tb_linear_bias_grad_batched;
  import linear_bias_grad_batched_pkg::*;
  localparam logic [31:0] A0 = 32'd8, D0 = 32'd4;
  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic wt;} wr_t;
  logic clk = 1'b0, rst_l = 1'b0, go = 1'b0, accumulate = 1'b0;
  logic [15:0] n_rows = '0, n_cols = '0;
  logic busy, done, err;
  logic [31:0] mem_a [64];
  logic [31:0] mem_d [64];
  logic [2:0] a_cnt, d_cnt;
  bit stall = 1'b0;
  int acc_cyc = 0;
  int errors = 0, checks = 0, base;
  wr_t exp_q[$], obs_q[$];
  linear_bias_grad_batched_if a_if ();
  linear_bias_grad_batched_if d_if ();
  linear_bias_grad_batched dut (.clk(clk), .rst_l(rst_l), .a(a_if), .d(d_if), .go(go),
    .accumulate(accumulate), .n_rows(n_rows), .n_cols(n_cols), .busy(busy), .done(done), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      a_if.done <= 1'b0;
      a_if.data_load <= '0;
      a_cnt <= '0;
    end else if (a_if.done) a_if.done <= 1'b0;
    else if (a_if.avail) begin
      if (a_cnt == 3'd0) begin
        a_if.done <= 1'b1;
        a_if.data_load <= mem_a[a_if.ptr[5:0]];
        a_cnt <= stall ? 3'($urandom_range(0, 7)) : 3'd0;
      end else a_cnt <= a_cnt - 3'd1;
    end
  end
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      d_if.done <= 1'b0;
      d_if.data_load <= '0;
      d_cnt <= '0;
    end else if (d_if.done) d_if.done <= 1'b0;
    else if (d_if.avail) begin
      if (d_cnt == 3'd0) begin
        d_if.done <= 1'b1;
        d_if.data_load <= mem_d[d_if.ptr[5:0]];
        if (d_if.w_en) obs_q.push_back('{d_if.ptr, d_if.data_store, d_if.write_through});
        d_cnt <= stall ? 3'($urandom_range(0, 7)) : 3'd0;
      end else d_cnt <= d_cnt - 3'd1;
    end
  end
  always @(posedge clk)
    if (a_if.r_en | a_if.w_en | d_if.r_en | d_if.w_en) acc_cyc <= acc_cyc + 1;
  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic regions(input int a_len, input int d_len);
    a_if.region_begin = A0;
    a_if.region_end   = A0 + 32'(a_len);
    d_if.region_begin = D0;
    d_if.region_end   = D0 + 32'(d_len);
  endtask
  task automatic expect_col(input int j, input logic [31:0] v, input int cols);
    exp_q.push_back('{D0 + 32'(j), v, j == cols - 1});
  endtask
  task automatic run(input int rows, input int cols, input logic acc, input logic exp_err);
    @(negedge clk);
    n_rows = 16'(rows);
    n_cols = 16'(cols);
    accumulate = acc;
    go = 1'b1;
    for (int k = 0; k < 4000 && !done; k++) @(negedge clk);
    chk("done_seen", 65'(done), 65'd1);
    chk("err", 65'(err), 65'(exp_err));
    repeat (2) @(negedge clk);
    chk("done_held_go_high", 65'({done, busy}), 65'b10);
    go = 1'b0;
    @(negedge clk);
    chk("back_to_idle", 65'({done, busy}), 65'b00);
  endtask
  task automatic drain(input string tag);
    chk({tag, "_write_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) chk({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic load_t2();
    for (int i = 0; i < 6; i++) mem_a[A0 + 32'(i)] = (i % 2 == 0) ? 32'h3F80_0000 : 32'h4000_0000;
    regions(6, 2);
    expect_col(0, 32'h4040_0000, 2);
    expect_col(1, 32'h40C0_0000, 2);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = '0;
      mem_d[i] = '0;
    end
    regions(16, 8);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 65'({busy, done, err, a_if.r_en, a_if.avail, d_if.w_en, d_if.avail}), 65'd0);
    chk("reset_ptrs", 65'({a_if.ptr, d_if.ptr}), 65'd0);
    rst_l = 1'b1;
    // 1 row x 4 cols: each column sum is the single element
    mem_a[A0] = 32'h3F80_0000; mem_a[A0+1] = 32'h4000_0000;
    mem_a[A0+2] = 32'h4040_0000; mem_a[A0+3] = 32'h3F00_0000;
    regions(4, 4);
    expect_col(0, 32'h3F80_0000, 4); expect_col(1, 32'h4000_0000, 4);
    expect_col(2, 32'h4040_0000, 4); expect_col(3, 32'h3F00_0000, 4);
    run(1, 4, 1'b0, 1'b0);
    drain("t1");
    // 3 x 2 plain sum
    load_t2();
    run(3, 2, 1'b0, 1'b0);
    drain("t2");
    // accumulate into preloaded 0.5
    for (int i = 0; i < 4; i++) mem_a[A0 + 32'(i)] = 32'h3F80_0000;
    mem_d[D0] = 32'h3F00_0000; mem_d[D0+1] = 32'h3F00_0000;
    regions(4, 2);
    expect_col(0, 32'h4020_0000, 2); expect_col(1, 32'h4020_0000, 2);
    run(2, 2, 1'b1, 1'b0);
    drain("t3");
    // rounding ties, sticky round-up and exact cancellation
    mem_a[A0] = 32'h3F80_0000; mem_a[A0+1] = 32'h3F80_0000; mem_a[A0+2] = 32'h3F80_0000;
    mem_a[A0+3] = 32'h3380_0000; mem_a[A0+4] = 32'h3380_0001; mem_a[A0+5] = 32'hBF80_0000;
    regions(6, 3);
    expect_col(0, 32'h3F80_0000, 3); expect_col(1, 32'h3F80_0001, 3); expect_col(2, 32'h0000_0000, 3);
    run(2, 3, 1'b0, 1'b0);
    drain("t_round");
    // zero-size runs finish two cycles after go with no accesses
    base = acc_cyc;
    for (int z = 0; z < 2; z++) begin
      @(negedge clk);
      n_rows = (z == 0) ? 16'd0 : 16'd2;
      n_cols = (z == 0) ? 16'd2 : 16'd0;
      accumulate = 1'b0;
      go = 1'b1;
      @(negedge clk);
      chk("zero_not_done_yet", 65'(done), 65'd0);
      @(negedge clk);
      chk("zero_done_2cyc", 65'({done, err}), 65'b10);
      go = 1'b0;
      @(negedge clk);
    end
    chk("zero_no_access", 65'(acc_cyc - base), 65'd0);
    // region bound violations
    base = acc_cyc;
    regions(4, 8);
    run(3, 2, 1'b0, 1'b1);
    regions(16, 1);
    run(1, 2, 1'b0, 1'b1);
    chk("err_no_access", 65'(acc_cyc - base), 65'd0);
    drain("t5");
    // random stalls
    stall = 1'b1;
    load_t2();
    run(3, 2, 1'b0, 1'b0);
    drain("t6_stall");
    // reset in the middle of a gradient read
    load_t2();
    exp_q.delete();
    @(negedge clk);
    n_rows = 16'd3; n_cols = 16'd2; accumulate = 1'b0; go = 1'b1;
    for (int k = 0; k < 200 && !a_if.r_en; k++) @(negedge clk);
    chk("rd_grad_reached", 65'(a_if.r_en), 65'd1);
    rst_l = 1'b0;
    go = 1'b0;
    #1;
    chk("midrun_reset_outputs", 65'({busy, done, err, a_if.r_en, a_if.avail, d_if.w_en, d_if.avail, d_if.write_through}), 65'd0);
    chk("midrun_reset_bus", 65'({a_if.ptr, d_if.data_store}), 65'd0);
    chk("midrun_reset_state", 65'(dut.state_q), 65'(IDLE));
    @(negedge clk);
    rst_l = 1'b1;
    drain("t6_reset");
    load_t2();
    run(3, 2, 1'b0, 1'b0);
    drain("t6_rerun");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
